mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage MIPS pipeline: consumes the EX/MEM register outputs, performs data-memory stores and loads (word, halfword, byte), and registers the results into the MEM/WB boundary. It is the downstream end of the EX/MEM interface and the upstream end of write-back. Data memory is internal, little-endian, word-organised.

## Interface
- DEPTH_WORDS, 1024, data memory depth in 32-bit words (power of two)
- AW, 10, word-index width, log2(DEPTH_WORDS)

- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- instr_M  in  32  instruction in MEM
- PC4_M  in  32  PC+4 of instr_M
- PC8_M  in  32  PC+8 of instr_M
- AO_M  in  32  ALU result / effective byte address
- MEMD_M  in  32  store data (rt, forwarded)
- RegW_M  in  1  register-write enable of instr_M
- instr_W  out  32  registered instr_M
- PC4_W  out  32  registered PC4_M
- PC8_W  out  32  registered PC8_M
- AO_W  out  32  registered AO_M
- DR_W  out  32  load data, already extended
- RegW_W  out  1  register-write enable into WB
- align_err_W  out  1  misaligned access flag for instr_W

## Operation
- Decode opcode instr_M[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2b, sh 0x29, sb 0x28; all else no memory access.
- Word index = AO_M[AW+1:2]; upper address bits ignored (wrap modulo 4*DEPTH_WORDS bytes).
- Store: byte enables from AO_M[1:0]; sw all four; sh bytes {1,0} if AO_M[1]=0 else {3,2}, data MEMD_M[15:0]; sb one byte at offset AO_M[1:0], data MEMD_M[7:0]. Unenabled bytes unchanged.
- Load: word read combinationally from array; lb/lh sign-extend, lbu/lhu zero-extend selected byte/half; lw whole word; non-load DR_W=0.
- Pipeline fields pass through unchanged except RegW_W (forced 0 on align error when checking enabled).

## Timing
- Reset (synchronous): all outputs 0; every memory word cleared to 0; any store present in the reset cycle is discarded.
- Store commits at the posedge ending its MEM cycle.
- Load latency 1: DR_W valid the cycle after instr_M in MEM.
- Store at cycle n followed by load of same word at n+1: load returns new data (no bypass needed; write lands before read).
- Back-to-back stores to same word, different bytes: both merge.
- No stall/flush inputs; a bubble is instr_M=0 (sll $0) and performs no access.

## Configuration
- MEM_ALIGN_CHECK_EN defined: lw/sw with AO_M[1:0]!=0, lh/lhu/sh with AO_M[0]!=0 are misaligned -> store suppressed, DR_W=0, RegW_W=0, align_err_W=1 for that instruction's W cycle.
- Not defined: AO_M[1:0] (word) or AO_M[0] (half) ignored, access proceeds aligned-down; align_err_W tied 0.

## Structure
- Shared header mips_defs: opcode constants above, DEPTH_WORDS default.
- Sub-module load_ext: combinational byte/half select and sign/zero extension from (word, AO[1:0], opcode); reused by any future cache path.
- Byte-enable generation and array write stay in mem_stage.

## Test plan
- Reset asserted with stores pending -> all W outputs 0, read of address 0x0 returns 0x00000000.
- sw 0x12345678 @0x10; next cycle lw @0x10 -> DR_W=0x12345678 one cycle later, RegW_W=1.
- sb 0x80 @0x13, then lb @0x13 -> DR_W=0xFFFFFF80; lbu @0x13 -> 0x00000080; lw @0x10 -> 0x80345678.
- sh 0xBEEF @0x22 on word holding 0x11112222 -> word 0xBEEF2222; lh @0x22 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
- Address wrap: sw 0xA5A5A5A5 @0x1000 (DEPTH_WORDS=1024) -> lw @0x0 returns 0xA5A5A5A5.
- With MEM_ALIGN_CHECK_EN: sw @0x11 -> memory unchanged, align_err_W=1, RegW_W=0; without it: word @0x10 overwritten, align_err_W=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared MIPS definitions for the memory stage: load/store opcodes and default memory depth.
package mem_stage_pkg;

  localparam int unsigned MEM_DEPTH_WORDS = 1024;
  localparam int unsigned OP_W            = 6;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2b;

  function automatic logic is_half_op(input logic [OP_W-1:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Byte/halfword select and sign/zero extension of a little-endian memory word.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0]     word_i,
  input  logic [1:0]      off_i,
  input  logic [OP_W-1:0] op_i,
  output logic [31:0]     data_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = word_i[7:0];
    case (off_i)
      2'd1:    byte_c = word_i[15:8];
      2'd2:    byte_c = word_i[23:16];
      2'd3:    byte_c = word_i[31:24];
      default: byte_c = word_i[7:0];
    endcase
    half_c = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_c_o = '0;
    case (op_i)
      OP_LW:   data_c_o = word_i;
      OP_LH:   data_c_o = {{16{half_c[15]}}, half_c};
      OP_LHU:  data_c_o = {16'h0000, half_c};
      OP_LB:   data_c_o = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  data_c_o = {24'h000000, byte_c};
      default: data_c_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: internal little-endian data memory, stores/loads, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN flags and suppresses misaligned word/half accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS,
  parameter int unsigned AW          = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] MEMD_M,
  input  logic        RegW_M,
  output logic [31:0] instr_W,
  output logic [31:0] PC4_W,
  output logic [31:0] PC8_W,
  output logic [31:0] AO_W,
  output logic [31:0] DR_W,
  output logic        RegW_W,
  output logic        align_err_W
);

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [OP_W-1:0] op_c;
  logic [AW-1:0]   widx_c;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic [31:0]     ext_c;
  logic            misalign_c;
  logic            unused_ao;

  assign op_c      = instr_M[31:26];
  assign widx_c    = AO_M[AW+1:2];
  assign unused_ao = ^AO_M[31:AW+2];

  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    misalign_c = (is_word_op(op_c) && (AO_M[1:0] != 2'b00)) ||
                 (is_half_op(op_c) && AO_M[0]);
`else
    misalign_c = 1'b0;
`endif
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = MEMD_M;
    case (op_c)
      OP_SW: be_c = 4'b1111;
      OP_SH: begin
        be_c    = AO_M[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{MEMD_M[15:0]}};
      end
      OP_SB: begin
        be_c    = 4'b0001 << AO_M[1:0];
        wdata_c = {4{MEMD_M[7:0]}};
      end
      default: be_c = 4'b0000;
    endcase
    if (misalign_c) be_c = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[widx_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

  mem_stage_load_ext u_load_ext (
    .word_i   (mem_q[widx_c]),
    .off_i    (AO_M[1:0]),
    .op_i     (op_c),
    .data_c_o (ext_c)
  );

  // MEM/WB boundary register
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_W     <= '0;
      PC4_W       <= '0;
      PC8_W       <= '0;
      AO_W        <= '0;
      DR_W        <= '0;
      RegW_W      <= 1'b0;
      align_err_W <= 1'b0;
    end else begin
      instr_W     <= instr_M;
      PC4_W       <= PC4_M;
      PC8_W       <= PC8_M;
      AO_W        <= AO_M;
      DR_W        <= misalign_c ? 32'h0 : ext_c;
      RegW_W      <= RegW_M & ~misalign_c;
      align_err_W <= misalign_c;
    end
  end

endmodule
